// File: rtl/sum_pipe_pkg.sv
// -----------------------------------------------------------------------------
// sum_pipe_pkg
//   Shared definitions for the sum_pipe_mon adder-pipeline monitor:
//   data/idx widths, monitor FSM state type and small arithmetic helpers.
// -----------------------------------------------------------------------------
package sum_pipe_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned IDX_W  = 4;

  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_TRACK = 2'd1,
    ST_LOST  = 2'd2
  } mon_state_e;

  // Adder reference: carry out is dropped by the result width.
  function automatic logic [DATA_W-1:0] sum_mod(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  // Next expected sequence tag; 15 -> 0 wraps naturally.
  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] i);
    return i + IDX_ONE;
  endfunction

endpackage

// File: rtl/sum_pipe_mon_opnd_hist.sv
// -----------------------------------------------------------------------------
// opnd_hist
//   Operand delay line for the monitor. The live inputs form entry 0 and
//   LAT registered stages follow, so the history spans LAT+1 entries; the
//   output is the operand pair captured LAT cycles earlier.
//
// Ports
//   clk      in   rising-edge clock
//   reset_L  in   asynchronous active-low reset, clears every stage
//   dataA    in   operand A presented this cycle
//   dataB    in   operand B presented this cycle
//   dlyA     out  operand A from LAT cycles earlier
//   dlyB     out  operand B from LAT cycles earlier
// -----------------------------------------------------------------------------
module opnd_hist
  import sum_pipe_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] dataA,
  input  logic [DATA_W-1:0] dataB,
  output logic [DATA_W-1:0] dlyA,
  output logic [DATA_W-1:0] dlyB
);

  // histX_q[k] holds the operand captured k cycles ago.
  logic [DATA_W-1:0] histA_q [1:LAT];
  logic [DATA_W-1:0] histB_q [1:LAT];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int unsigned k = 1; k <= LAT; k++) begin
        histA_q[k] <= '0;
        histB_q[k] <= '0;
      end
    end else begin
      histA_q[1] <= dataA;
      histB_q[1] <= dataB;
      for (int unsigned k = 2; k <= LAT; k++) begin
        histA_q[k] <= histA_q[k-1];
        histB_q[k] <= histB_q[k-1];
      end
    end
  end

  assign dlyA = histA_q[LAT];
  assign dlyB = histB_q[LAT];

endmodule

// File: rtl/sum_pipe_mon.sv
// -----------------------------------------------------------------------------
// sum_pipe_mon
//   Monitor for a 4-bit pipelined adder with latency LAT. Keeps the operand
//   history, checks the adder result and its sequence tag each cycle, and
//   keeps saturating match/error counters.
//
//   FSM: FILL  - history refilling after reset, no compares
//        TRACK - result and tag checked every cycle
//        LOST  - tag discontinuity seen; waits for two continuous tags
//
// Parameters
//   LAT    adder latency in cycles (1..3)
//   CNT_W  width of the saturating counters
//
// Ports
//   clk         in   rising-edge clock
//   reset_L     in   asynchronous active-low reset
//   dataA/B     in   operands presented to the adder this cycle
//   sum_in      in   adder result this cycle
//   idx_in      in   adder sequence tag this cycle
//   locked      out  high while in TRACK
//   mismatch    out  registered pulse: result differed from expected
//   seq_err     out  registered pulse: tag was not previous+1
//   err_cnt     out  saturating count of mismatch pulses
//   match_cnt   out  saturating count of compared-and-equal cycles
//   sticky_err  out  latched error flag; only built when the macro
//                    SUM_PIPE_MON_STICKY_EN is defined, otherwise tied 0
// -----------------------------------------------------------------------------
module sum_pipe_mon
  import sum_pipe_pkg::*;
#(
  parameter int unsigned LAT   = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] dataA,
  input  logic [DATA_W-1:0] dataB,
  input  logic [DATA_W-1:0] sum_in,
  input  logic [IDX_W-1:0]  idx_in,
  output logic              locked,
  output logic              mismatch,
  output logic              seq_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              sticky_err
);

  localparam logic [1:0]       FILL_LAST = 2'(LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] dlyA;
  logic [DATA_W-1:0] dlyB;
  logic [DATA_W-1:0] exp_sum;

  opnd_hist #(
    .LAT(LAT)
  ) u_hist (
    .clk    (clk),
    .reset_L(reset_L),
    .dataA  (dataA),
    .dataB  (dataB),
    .dlyA   (dlyA),
    .dlyB   (dlyB)
  );

  assign exp_sum = sum_mod(dlyA, dlyB);

  mon_state_e       state_q, state_d;
  logic [1:0]       fill_q, fill_d;
  logic             good_q, good_d;
  logic [IDX_W-1:0] prev_idx_q, prev_idx_d;
  logic             mismatch_q, mismatch_d;
  logic             seq_err_q, seq_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic idx_cont;
  logic sum_eq;

  assign idx_cont = (idx_in == idx_next(prev_idx_q));
  assign sum_eq   = (sum_in == exp_sum);

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    good_d      = good_q;
    prev_idx_d  = prev_idx_q;
    mismatch_d  = 1'b0;
    seq_err_d   = 1'b0;
    err_cnt_d   = err_cnt_q;
    match_cnt_d = match_cnt_q;

    unique case (state_q)
      ST_FILL: begin
        if (fill_q == FILL_LAST) begin
          state_d    = ST_TRACK;
          prev_idx_d = idx_in;
        end else begin
          fill_d = fill_q + 2'd1;
        end
      end

      ST_TRACK: begin
        prev_idx_d = idx_in;
        // A tag break invalidates the pairing of sum_in with history,
        // so it takes priority and suppresses the sum compare.
        if (!idx_cont) begin
          seq_err_d = 1'b1;
          state_d   = ST_LOST;
          good_d    = 1'b0;
        end else if (!sum_eq) begin
          mismatch_d = 1'b1;
          if (err_cnt_q != CNT_MAX) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
          end
        end else begin
          if (match_cnt_q != CNT_MAX) begin
            match_cnt_d = match_cnt_q + CNT_ONE;
          end
        end
      end

      ST_LOST: begin
        prev_idx_d = idx_in;
        // good_q marks one continuous tag already seen; the second relocks.
        if (idx_cont) begin
          if (good_q) begin
            state_d = ST_TRACK;
            good_d  = 1'b0;
          end else begin
            good_d = 1'b1;
          end
        end else begin
          good_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_FILL;
      fill_q      <= '0;
      good_q      <= 1'b0;
      prev_idx_q  <= '0;
      mismatch_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      good_q      <= good_d;
      prev_idx_q  <= prev_idx_d;
      mismatch_q  <= mismatch_d;
      seq_err_q   <= seq_err_d;
      err_cnt_q   <= err_cnt_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign locked    = (state_q == ST_TRACK);
  assign mismatch  = mismatch_q;
  assign seq_err   = seq_err_q;
  assign err_cnt   = err_cnt_q;
  assign match_cnt = match_cnt_q;

`ifdef SUM_PIPE_MON_STICKY_EN
  logic sticky_q;

  // Set together with the first error pulse so both become visible at once.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sticky_q <= 1'b0;
    end else if (mismatch_d || seq_err_d) begin
      sticky_q <= 1'b1;
    end
  end

  assign sticky_err = sticky_q;
`else
  assign sticky_err = 1'b0;
`endif

endmodule

// File: tb/tb_sum_pipe_mon.sv
// -----------------------------------------------------------------------------
// tb_sum_pipe_mon
//   Directed bench for sum_pipe_mon (LAT=2, CNT_W=8). A behavioural model of
//   the monitor runs alongside the DUT; a compare process checks every output
//   on every falling edge, and literal expectations pin key points.
// -----------------------------------------------------------------------------
module tb_sum_pipe_mon;

  localparam int LAT   = 2;
  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_L;
  logic [3:0]       dataA, dataB, sum_in, idx_in;
  logic             locked, mismatch, seq_err, sticky_err;
  logic [CNT_W-1:0] err_cnt, match_cnt;

  always #5 clk = ~clk;

  sum_pipe_mon #(
    .LAT  (LAT),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .dataA     (dataA),
    .dataB     (dataB),
    .sum_in    (sum_in),
    .idx_in    (idx_in),
    .locked    (locked),
    .mismatch  (mismatch),
    .seq_err   (seq_err),
    .err_cnt   (err_cnt),
    .match_cnt (match_cnt),
    .sticky_err(sticky_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_filled, m_lk, m_mis, m_seq, m_sticky;
  int m_since, m_run, m_prev, m_err, m_match;
  int m_sums[$];

  always @(posedge clk or negedge reset_L) begin
    int  expv;
    bit  cont;
    if (!reset_L) begin
      m_filled = 0; m_lk = 0; m_mis = 0; m_seq = 0; m_sticky = 0;
      m_since = 0; m_run = 0; m_prev = 0; m_err = 0; m_match = 0;
      m_sums.delete();
    end else begin
      expv  = (m_sums.size() == LAT) ? m_sums[0] : 0;
      m_mis = 0;
      m_seq = 0;
      if (!m_filled) begin
        m_since++;
        if (m_since == LAT) begin
          m_filled = 1;
          m_lk     = 1;
          m_prev   = int'(idx_in);
        end
      end else begin
        cont = (int'(idx_in) == (m_prev + 1) % 16);
        if (m_lk) begin
          if (!cont) begin
            m_seq = 1; m_lk = 0; m_run = 0;
          end else if (int'(sum_in) != expv) begin
            m_mis = 1;
            if (m_err < SAT) m_err++;
          end else begin
            if (m_match < SAT) m_match++;
          end
        end else begin
          if (cont) begin
            m_run++;
            if (m_run == 2) begin m_lk = 1; m_run = 0; end
          end else begin
            m_run = 0;
          end
        end
        m_prev = int'(idx_in);
      end
      if (m_mis || m_seq) m_sticky = 1;
      m_sums.push_back((int'(dataA) + int'(dataB)) % 16);
      if (m_sums.size() > LAT) void'(m_sums.pop_front());
    end
  end

  function automatic bit exp_sticky();
`ifdef SUM_PIPE_MON_STICKY_EN
    return m_sticky;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("locked",     32'(locked),     32'(m_lk));
    chk("mismatch",   32'(mismatch),   32'(m_mis));
    chk("seq_err",    32'(seq_err),    32'(m_seq));
    chk("err_cnt",    32'(err_cnt),    32'(m_err));
    chk("match_cnt",  32'(match_cnt),  32'(m_match));
    chk("sticky_err", 32'(sticky_err), 32'(exp_sticky()));
  end

  // ---------------- stimulus driver (ideal adder with fault injection) ----
  int         drv_pipe[$];
  logic [3:0] idx_ctr = 4'd0;
  bit         rel_pending = 1'b1;

  // smode: 0 ideal result, 1 forced value sval, 2 ideal with bit 0 flipped
  task automatic step(input int a, input int b, input int smode = 0,
                      input int sval = 0, input bit ov_i = 1'b0, input int ival = 0);
    int ideal;
    @(posedge clk);
    #2;
    if (rel_pending) begin
      reset_L     = 1'b1;
      rel_pending = 1'b0;
    end
    dataA = 4'(a);
    dataB = 4'(b);
    drv_pipe.push_back((a + b) % 16);
    if (drv_pipe.size() > LAT + 1) void'(drv_pipe.pop_front());
    ideal = (drv_pipe.size() == LAT + 1) ? drv_pipe[0] : 0;
    case (smode)
      1:       sum_in = 4'(sval);
      2:       sum_in = 4'(ideal ^ 1);
      default: sum_in = 4'(ideal);
    endcase
    if (ov_i) idx_ctr = 4'(ival);
    idx_in  = idx_ctr;
    idx_ctr = idx_ctr + 4'd1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    reset_L = 1'b0;
    drv_pipe.delete();
    rel_pending = 1'b1;
    #1;
    chk("async_locked",    32'(locked),    0);
    chk("async_mismatch",  32'(mismatch),  0);
    chk("async_seq_err",   32'(seq_err),   0);
    chk("async_err_cnt",   32'(err_cnt),   0);
    chk("async_match_cnt", 32'(match_cnt), 0);
    chk("async_sticky",    32'(sticky_err), 0);
  endtask

  initial begin
    int n;
    reset_L = 1'b0;
    dataA   = '0;
    dataB   = '0;
    sum_in  = '0;
    idx_in  = '0;
    repeat (2) @(posedge clk);

    // Fill then track with A=3, B=4 -> sum 7
    step(3, 4);
    repeat (LAT - 1) step(3, 4);
    @(negedge clk);
    chk("fill_not_locked", 32'(locked), 0);
    step(3, 4);
    @(negedge clk);
    chk("locked_after_lat", 32'(locked), 1);
    chk("match_start", 32'(match_cnt), 0);
    repeat (4) step(3, 4);
    @(negedge clk);
    chk("match_after4", 32'(match_cnt), 4);
    chk("err_zero", 32'(err_cnt), 0);

    // Single corrupted result: expected 9, presented 8
    repeat (LAT) step(4, 5);
    step(4, 5, 1, 8);
    step(4, 5);
    @(negedge clk);
    chk("mismatch_pulse", 32'(mismatch), 1);
    chk("err_one", 32'(err_cnt), 1);
`ifdef SUM_PIPE_MON_STICKY_EN
    chk("sticky_set", 32'(sticky_err), 1);
`else
    chk("sticky_tied", 32'(sticky_err), 0);
`endif
    step(4, 5);
    @(negedge clk);
    chk("mismatch_single", 32'(mismatch), 0);

    // Carry dropped: 15+15 -> 14
    repeat (LAT + 2) step(15, 15);
    @(negedge clk);
    chk("carry_no_mismatch", 32'(mismatch), 0);
    chk("carry_err_hold", 32'(err_cnt), 1);

    // Tag wrap 14,15,0,1 is continuous
    n = 0;
    while (idx_ctr != 4'd14 && n < 16) begin
      step(3, 4);
      n++;
    end
    repeat (4) begin
      step(3, 4);
      @(negedge clk);
      chk("wrap_no_seq", 32'(seq_err), 0);
      chk("wrap_locked", 32'(locked), 1);
    end
    // 1 -> 3 breaks, 4,5 relock
    step(3, 4, 0, 0, 1'b1, 3);
    step(3, 4);
    @(negedge clk);
    chk("break_seq_err", 32'(seq_err), 1);
    chk("break_unlocked", 32'(locked), 0);
    step(3, 4);
    @(negedge clk);
    chk("lost_one_good", 32'(locked), 0);
    step(3, 4);
    @(negedge clk);
    chk("relocked", 32'(locked), 1);

    // Simultaneous bad sum and tag break: only seq_err
    step(3, 4, 2, 0, 1'b1, 9);
    step(3, 4);
    @(negedge clk);
    chk("both_seq_err", 32'(seq_err), 1);
    chk("both_no_mismatch", 32'(mismatch), 0);
    chk("both_err_hold", 32'(err_cnt), 1);
    repeat (4) step(3, 4);

    // Saturation: 300 corrupted results
    repeat (300) step(3, 4, 2);
    step(3, 4);
    @(negedge clk);
    chk("err_saturated", 32'(err_cnt), SAT);
    repeat (3) step(3, 4, 2);
    @(negedge clk);
    chk("err_stays_sat", 32'(err_cnt), SAT);

    // Reset pulse mid-track, then refill
    pulse_reset();
    n = 0;
    do begin
      step(3, 4);
      n++;
      @(negedge clk);
    end while (!locked && n < 10);
    chk("relock_cycles", 32'(n), 32'(LAT + 1));
    repeat (3) step(3, 4);
    @(negedge clk);
    chk("post_reset_match", 32'(match_cnt), 3);
    chk("post_reset_err", 32'(err_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_pipe_mon.md
SUM_PIPE_MON -- requirements
Module: sum_pipe_mon

Interface
REQ-001 Parameter LAT, default 2, meaning cycles from operand presentation to result at the 4-bit pipelined adder output; legal range 1..3.
REQ-002 Parameter CNT_W, default 8, meaning width of the saturating error and match counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_L  input  1  reset, asynchronous and active-low.
REQ-005 dataA  input  4  operand A presented to the adder this cycle.
REQ-006 dataB  input  4  operand B presented to the adder this cycle.
REQ-007 sum_in  input  4  adder result (sum30_dd side) this cycle.
REQ-008 idx_in  input  4  adder sequence tag (idx_dd side) this cycle.
REQ-009 locked  output  1  high while the monitor is in TRACK.
REQ-010 mismatch  output  1  one-cycle pulse, sum_in differs from expected.
REQ-011 seq_err  output  1  one-cycle pulse, idx_in not previous+1 mod 16.
REQ-012 err_cnt  output  CNT_W  saturating count of mismatch pulses.
REQ-013 match_cnt  output  CNT_W  saturating count of compared-and-equal cycles.
REQ-014 sticky_err  output  1  latched error flag (see Configuration).

Function
REQ-015 Monitor SHALL keep operand history as a shift register, one entry per cycle, depth LAT+1; expected value = (A+B) mod 16 of the entry captured LAT cycles earlier; carry out discarded.
REQ-016 FSM states SHALL be FILL, TRACK, LOST; encoding in the shared package.
REQ-017 FILL: fill counter increments each cycle; on reaching LAT the FSM SHALL move to TRACK and capture idx_in as prev_idx; no compares in FILL.
REQ-018 TRACK: every cycle, sum_in SHALL be compared with expected; unequal -> mismatch=1 next cycle and err_cnt+1; equal -> match_cnt+1.
REQ-019 TRACK: if idx_in != prev_idx+1 (4-bit wrap, 15->0 is continuous) the monitor SHALL pulse seq_err, skip the sum compare that cycle, and go to LOST.
REQ-020 LOST: no sum compares; counters hold; two consecutive continuous idx_in values SHALL return the FSM to TRACK; any discontinuity restarts the count.
REQ-021 prev_idx SHALL update with idx_in every cycle in TRACK and LOST.
REQ-022 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 Simultaneous sum mismatch and idx discontinuity in TRACK: seq_err only, mismatch stays 0, err_cnt unchanged.
REQ-024 Output registers: mismatch and seq_err registered, visible exactly one cycle after the offending inputs.

Reset
REQ-025 reset_L low SHALL immediately force: state FILL, fill counter 0, history 0, prev_idx 0, locked 0, mismatch 0, seq_err 0, err_cnt 0, match_cnt 0, sticky_err 0.
REQ-026 Reset asserted mid-TRACK SHALL discard history; after release the monitor SHALL refill for LAT cycles before comparing.

Configuration
REQ-027 Macro SUM_PIPE_MON_STICKY_EN defined: sticky_err SHALL set on the first mismatch or seq_err pulse and hold until reset.
REQ-028 Macro undefined: sticky_err SHALL be tied 0, no sticky register synthesised.

Structure
REQ-029 Package sum_pipe_pkg SHALL hold the FSM state typedef, data width constant 4 and idx width constant 4.
REQ-030 Sub-module opnd_hist SHALL implement the parameterised operand delay line (inputs dataA/dataB, output delayed pair); FSM, compare and counters stay in sum_pipe_mon.

Verification
REQ-031 Reset release, feed correct adder model, A=3,B=4 constant -> locked=1 after LAT cycles, sum_in=7 compared, match_cnt increments each cycle, err_cnt=0.
REQ-032 In TRACK, corrupt one result (expected 9, sum_in=8) -> mismatch pulse one cycle later, err_cnt=1, sticky_err=1 only with SUM_PIPE_MON_STICKY_EN.
REQ-033 idx sequence 14,15,0,1 -> no seq_err; then 1,3 -> seq_err pulse, locked=0; next 4,5 -> locked=1 again.
REQ-034 A=15,B=15 -> expected 14 (carry dropped), sum_in=14 -> no mismatch.
REQ-035 Force 300 mismatches with CNT_W=8 -> err_cnt holds 255.
REQ-036 Assert reset_L low for 1 cycle mid-TRACK -> all outputs 0 asynchronously, locked returns only after LAT refill cycles.
